intersection_scheduler: RTL and testbench

//  Sequences a two-approach intersection (main road / side road) on a 1 Hz tick derived from clk.

---
 rtl/traffic_pkg.sv | 27 ++
 rtl/tick_gen.sv | 37 +++
 rtl/intersection_scheduler.sv | 142 ++++++++++++++
 tb/tb_intersection_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared phase encoding, lamp patterns and dwell helper for the intersection scheduler.
package traffic_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MAIN_G = 3'd1,
        MAIN_Y = 3'd2,
        CLR_M  = 3'd3,
        SIDE_G = 3'd4,
        SIDE_Y = 3'd5,
        CLR_S  = 3'd6,
        WALK   = 3'd7
    } phase_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    localparam int unsigned         DWELL_W   = 5;
    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

    // True on the tick that completes n ticks of dwell (or any later tick).
    function automatic logic dwell_reached(input logic [DWELL_W-1:0] dwell, input int unsigned n);
        return (32'(dwell) + 32'd1) >= n;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_HZ clocks; held at zero while en=0.
module tick_gen #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned      CNT_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: flops use <= so each one samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/intersection_scheduler.sv
// Two-approach intersection sequencer with yellow and all-red clearance between greens.
// Optional pedestrian phase enabled by defining INTERSECTION_PED_EN.
module intersection_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned MIN_GREEN = 5,
    parameter int unsigned MAX_GREEN = 15,
    parameter int unsigned YELLOW_S  = 3,
    parameter int unsigned ALL_RED_S = 1,
    parameter int unsigned WALK_S    = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       req_main,
    input  logic       req_side,
    input  logic       ped_btn,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk,
    output logic [2:0] phase,
    output logic       tick_o
);

    logic               tick;
    phase_t             state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               ped_pending_q, ped_pending_d;
    logic               ped_edge;
    logic               unused_inputs;

    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (enable),
        .tick (tick)
    );

    assign tick_o = tick;

`ifdef INTERSECTION_PED_EN
    // [0],[1] synchronise the raw button; [2] holds the previous synchronised level.
    logic [2:0] ped_shift_q, ped_shift_d;

    always_comb begin
        ped_shift_d = {ped_shift_q[1:0], ped_btn};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_shift_q <= '0;
        end else begin
            ped_shift_q <= ped_shift_d;
        end
    end

    assign ped_edge      = ped_shift_q[1] & ~ped_shift_q[2];
    assign unused_inputs = req_main;
`else
    assign ped_edge      = 1'b0;
    assign unused_inputs = req_main ^ ped_btn;
`endif

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else if (tick) begin
            case (state_q)
                IDLE:   state_d = CLR_S;
                MAIN_G: if (dwell_reached(dwell_q, MIN_GREEN) && (req_side || ped_pending_q))
                            state_d = MAIN_Y;
                MAIN_Y: if (dwell_reached(dwell_q, YELLOW_S)) state_d = CLR_M;
                CLR_M:  if (dwell_reached(dwell_q, ALL_RED_S)) begin
                            // A waiting pedestrian beats the side road; side is served next cycle round.
                            if (ped_pending_q)     state_d = WALK;
                            else if (req_side)     state_d = SIDE_G;
                            else                   state_d = MAIN_G;
                        end
                SIDE_G: if ((dwell_reached(dwell_q, MIN_GREEN) && !req_side) ||
                            dwell_reached(dwell_q, MAX_GREEN))
                            state_d = SIDE_Y;
                SIDE_Y: if (dwell_reached(dwell_q, YELLOW_S))  state_d = CLR_S;
                CLR_S:  if (dwell_reached(dwell_q, ALL_RED_S)) state_d = MAIN_G;
                WALK:   if (dwell_reached(dwell_q, WALK_S))    state_d = CLR_S;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        dwell_d = dwell_q;
        if (!enable || state_d != state_q) begin
            dwell_d = '0;
        end else if (tick && dwell_q != DWELL_MAX) begin
            dwell_d = dwell_q + DWELL_W'(1);
        end

        // Entering WALK clears the request and wins over a press landing on the same cycle.
        ped_pending_d = ped_pending_q;
        if (!enable || (state_d == WALK && state_q != WALK)) begin
            ped_pending_d = 1'b0;
        end else if (ped_edge && state_q != WALK) begin
            ped_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            dwell_q       <= '0;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dwell_q       <= dwell_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    // Lamps depend on the state register only, so inputs never glitch the heads.
    always_comb begin
        main_lights = LAMP_R;
        side_lights = LAMP_R;
        case (state_q)
            MAIN_G:  main_lights = LAMP_G;
            MAIN_Y:  main_lights = LAMP_Y;
            SIDE_G:  side_lights = LAMP_G;
            SIDE_Y:  side_lights = LAMP_Y;
            default: ;
        endcase
    end

`ifdef INTERSECTION_PED_EN
    assign walk = (state_q == WALK);
`else
    assign walk = 1'b0;
`endif

    assign phase = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench: expected lamp states are queued per tick and compared as each tick lands.
module tb_intersection_scheduler;

    localparam int unsigned CLK_HZ = 4;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    localparam logic [2:0] P_IDLE   = 3'd0;
    localparam logic [2:0] P_MAIN_G = 3'd1;
    localparam logic [2:0] P_MAIN_Y = 3'd2;
    localparam logic [2:0] P_CLR_M  = 3'd3;
    localparam logic [2:0] P_SIDE_G = 3'd4;
    localparam logic [2:0] P_SIDE_Y = 3'd5;
    localparam logic [2:0] P_CLR_S  = 3'd6;
    localparam logic [2:0] P_WALK   = 3'd7;

    typedef struct packed {
        logic [2:0] main;
        logic [2:0] side;
        logic       walk;
        logic [2:0] phase;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       req_main = 1'b0;
    logic       req_side = 1'b0;
    logic       ped_btn = 1'b0;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk;
    logic [2:0] phase;
    logic       tick_o;

    obs_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    intersection_scheduler #(.CLK_HZ(CLK_HZ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .req_main   (req_main),
        .req_side   (req_side),
        .ped_btn    (ped_btn),
        .main_lights(main_lights),
        .side_lights(side_lights),
        .walk       (walk),
        .phase      (phase),
        .tick_o     (tick_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] m, input logic [2:0] s,
                        input logic w, input logic [2:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({m, s, w, p});
            tag_q.push_back(tag);
        end
    endtask

    // Samples the DUT just after the clock edge that applied a tick.
    task automatic consume_entry();
        obs_t  got;
        obs_t  e;
        string tag;
        @(posedge clk);
        #1;
        got = {main_lights, side_lights, walk, phase};
        check("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            check(tag, 32'(got), 32'(e));
        end
    endtask

    task automatic wait_tick(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 4 * CLK_HZ + 4; i++) begin
            @(negedge clk);
            if (tick_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic observe(input int n);
        bit seen;
        for (int i = 0; i < n; i++) begin
            wait_tick(seen);
            check("tick_seen", 32'(seen), 32'd1);
            consume_entry();
        end
    endtask

    initial begin
        int pulses;
        int latency;

        // Reset state
        #2;
        check("rst_main", 32'(main_lights), 32'(R));
        check("rst_side", 32'(side_lights), 32'(R));
        check("rst_walk", 32'(walk), 32'd0);
        check("rst_phase", 32'(phase), 32'(P_IDLE));
        check("rst_tick", 32'(tick_o), 32'd0);

        // Out of reset but disabled: no ticks, still all-red
        @(posedge clk);
        #1 rst_n = 1'b1;
        pulses = 0;
        repeat (50) begin
            @(negedge clk);
            if (tick_o === 1'b1) pulses++;
        end
        check("disabled_tick_count", 32'(pulses), 32'd0);
        check("disabled_main", 32'(main_lights), 32'(R));
        check("disabled_side", 32'(side_lights), 32'(R));
        check("disabled_phase", 32'(phase), 32'(P_IDLE));

        // Enable with no requests: first tick after CLK_HZ cycles, clearance, then main rests
        @(posedge clk);
        #1 enable = 1'b1;
        latency = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            latency++;
            if (tick_o === 1'b1) break;
        end
        check("first_tick_latency", 32'(latency), 32'(CLK_HZ));
        push("startup_clr_s", R, R, 1'b0, P_CLR_S, 1);
        consume_entry();
        push("main_rest", G, R, 1'b0, P_MAIN_G, 40);
        observe(40);

        // Drop enable: all-red IDLE on the next edge
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("disable_phase", 32'(phase), 32'(P_IDLE));
        check("disable_main", 32'(main_lights), 32'(R));
        check("disable_side", 32'(side_lights), 32'(R));

        // Side request from the start, released at side green dwell 2
        req_side = 1'b1;
        enable   = 1'b1;
        push("s3_clr_s", R, R, 1'b0, P_CLR_S, 1);
        push("s3_main_g", G, R, 1'b0, P_MAIN_G, 5);
        push("s3_main_y", Y, R, 1'b0, P_MAIN_Y, 3);
        push("s3_clr_m", R, R, 1'b0, P_CLR_M, 1);
        push("s3_side_g", R, G, 1'b0, P_SIDE_G, 3);
        observe(13);
        req_side = 1'b0;
        push("s3_side_g_min", R, G, 1'b0, P_SIDE_G, 2);
        push("s3_side_y", R, Y, 1'b0, P_SIDE_Y, 3);
        push("s3_clr_s2", R, R, 1'b0, P_CLR_S, 1);
        push("s3_main_g2", G, R, 1'b0, P_MAIN_G, 1);
        observe(7);

        // Side request held: side green capped at MAX_GREEN
        req_side = 1'b1;
        push("s4_main_g", G, R, 1'b0, P_MAIN_G, 4);
        push("s4_main_y", Y, R, 1'b0, P_MAIN_Y, 3);
        push("s4_clr_m", R, R, 1'b0, P_CLR_M, 1);
        push("s4_side_g_max", R, G, 1'b0, P_SIDE_G, 15);
        push("s4_side_y", R, Y, 1'b0, P_SIDE_Y, 1);
        observe(24);

        // Drop enable during side yellow: straight to IDLE, no further yellow
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("yellow_abort_phase", 32'(phase), 32'(P_IDLE));
        check("yellow_abort_main", 32'(main_lights), 32'(R));
        check("yellow_abort_side", 32'(side_lights), 32'(R));
        req_side = 1'b0;

        // Pedestrian press at main green dwell 1
        enable = 1'b1;
        push("s5_clr_s", R, R, 1'b0, P_CLR_S, 1);
        push("s5_main_g", G, R, 1'b0, P_MAIN_G, 2);
        observe(3);
        ped_btn = 1'b1;
        repeat (2) @(posedge clk);
        #1 ped_btn = 1'b0;
`ifdef INTERSECTION_PED_EN
        push("s5_main_g_rest", G, R, 1'b0, P_MAIN_G, 3);
        push("s5_main_y", Y, R, 1'b0, P_MAIN_Y, 3);
        push("s5_clr_m", R, R, 1'b0, P_CLR_M, 1);
        push("s5_walk", R, R, 1'b1, P_WALK, 7);
        push("s5_clr_s2", R, R, 1'b0, P_CLR_S, 1);
        push("s5_main_g2", G, R, 1'b0, P_MAIN_G, 1);
        observe(16);
`else
        push("s5_main_ignores_ped", G, R, 1'b0, P_MAIN_G, 10);
        observe(10);
`endif

        // Asynchronous reset mid main green: lamps drop before the next edge
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_main", 32'(main_lights), 32'(R));
        check("async_rst_side", 32'(side_lights), 32'(R));
        check("async_rst_walk", 32'(walk), 32'd0);
        check("async_rst_phase", 32'(phase), 32'(P_IDLE));
        check("async_rst_tick", 32'(tick_o), 32'd0);
        #2 rst_n = 1'b1;

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
